inst_fetch_unit: RTL and testbench

- Responder to the control unit's fetch request.
- Accepts a one-cycle `inst_fetch` pulse plus the current PC.
- Performs a read on the instruction bus using a valid/ready address channel and a valid/ready data channel.
- Returns the fetched word with a one-cycle `inst_valid` pulse, which the control unit's IDLE state waits on.

---
 rtl/inst_fetch_unit_if.sv | 23 ++
 rtl/inst_fetch_unit.sv | 112 +++++++++++
 tb/tb_inst_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// Instruction-bus read channels: valid/ready address request and valid/ready data return.
// master = fetch unit side, slave = memory side.
interface inst_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  addr_valid;
  logic                  addr_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output addr_valid, addr, data_ready,
    input  addr_ready, data_valid, data
  );

  modport slave (
    input  addr_valid, addr, data_ready,
    output addr_ready, data_valid, data
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch responder: pc in, one-word bus read, inst_valid pulse 3 cycles after inst_fetch at best.
// Stalls indefinitely on either bus channel; fetches arriving while busy collapse into one latest-wins pending slot.
module inst_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_fetch,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  busy,
  inst_fetch_unit_if.master     bus
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  addr_vld_q, addr_vld_d;
  logic                  data_rdy_q, data_rdy_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  inst_vld_q, inst_vld_d;
  logic                  busy_q, busy_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    addr_vld_d = addr_vld_q;
    data_rdy_d = data_rdy_q;
    inst_d     = inst_q;
    inst_vld_d = 1'b0;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;

    // A fetch landing in the capture cycle is folded in here and reissued immediately below.
    if (inst_fetch && (state_q != S_IDLE)) begin
      pend_d    = 1'b1;
      pend_pc_d = pc;
    end

    case (state_q)
      S_IDLE: begin
        if (inst_fetch) begin
          state_d    = S_ADDR;
          addr_d     = pc;
          addr_vld_d = 1'b1;
        end
      end
      S_ADDR: begin
        if (addr_vld_q && bus.addr_ready) begin
          state_d    = S_DATA;
          addr_vld_d = 1'b0;
          data_rdy_d = 1'b1;
        end
      end
      S_DATA: begin
        if (bus.data_valid && data_rdy_q) begin
          inst_d     = bus.data;
          inst_vld_d = 1'b1;
          data_rdy_d = 1'b0;
          if (pend_d) begin
            state_d    = S_ADDR;
            addr_d     = pend_pc_d;
            addr_vld_d = 1'b1;
            pend_d     = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || pend_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      data_rdy_q <= 1'b0;
      inst_q     <= '0;
      inst_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      addr_vld_q <= addr_vld_d;
      data_rdy_q <= data_rdy_d;
      inst_q     <= inst_d;
      inst_vld_q <= inst_vld_d;
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign inst           = inst_q;
  assign inst_valid     = inst_vld_q;
  assign busy           = busy_q;
  assign bus.addr_valid = addr_vld_q;
  assign bus.addr       = addr_q;
  assign bus.data_ready = data_rdy_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed scenarios for inst_fetch_unit followed by a randomized run against a transaction-level model.
module tb_inst_fetch_unit;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_fetch;
  logic [AW-1:0] pc;
  logic [DW-1:0] inst;
  logic          inst_valid;
  logic          busy;

  int checks = 0;
  int errors = 0;

  inst_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  inst_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_fetch (inst_fetch),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory contents seen by the bench's bus responder.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic basic_fetch(input string tag);
    bus.addr_ready = 1'b1;
    bus.data_valid = 1'b1;
    bus.data       = 32'h0050_0093;
    @(negedge clk);
    inst_fetch = 1'b1;
    pc         = 32'h0000_0010;
    @(negedge clk);
    inst_fetch = 1'b0;
    check({tag, "_addr_vld"}, bus.addr_valid, 1'b1);
    check({tag, "_addr"}, bus.addr, 32'h10);
    check({tag, "_busy_on"}, busy, 1'b1);
    check({tag, "_iv_early"}, inst_valid, 1'b0);
    @(negedge clk);
    check({tag, "_addr_vld_drop"}, bus.addr_valid, 1'b0);
    check({tag, "_data_rdy"}, bus.data_ready, 1'b1);
    @(negedge clk);
    check({tag, "_iv"}, inst_valid, 1'b1);
    check({tag, "_inst"}, inst, 32'h0050_0093);
    check({tag, "_busy_off"}, busy, 1'b0);
    check({tag, "_data_rdy_off"}, bus.data_ready, 1'b0);
    @(negedge clk);
    check({tag, "_iv_once"}, inst_valid, 1'b0);
    check({tag, "_inst_hold"}, inst, 32'h0050_0093);
  endtask

  logic          m_inflight, m_pend, m_busy, exp_iv, prev_stall, drain, done_now;
  logic [31:0]   m_pend_pc, exp_word, cur_word, prev_addr, a;
  logic [31:0]   iq[$];

  initial begin
    rst            = 1'b0;
    inst_fetch     = 1'b0;
    pc             = '0;
    bus.addr_ready = 1'b0;
    bus.data_valid = 1'b0;
    bus.data       = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_inst", inst, 0);
    check("rst_iv", inst_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_addr_vld", bus.addr_valid, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_data_rdy", bus.data_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);

    basic_fetch("basic");

    // Address backpressure with early data offered before the handshake.
    bus.addr_ready = 1'b0;
    bus.data_valid = 1'b0;
    @(negedge clk);
    inst_fetch = 1'b1;
    pc         = 32'h0000_0020;
    @(negedge clk);
    inst_fetch     = 1'b0;
    bus.data_valid = 1'b1;
    bus.data       = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      check("bp_addr_vld", bus.addr_valid, 1'b1);
      check("bp_addr", bus.addr, 32'h20);
      check("bp_data_rdy", bus.data_ready, 1'b0);
      check("bp_inst_hold", inst, 32'h0050_0093);
      @(negedge clk);
    end
    check("bp_last_data_rdy", bus.data_ready, 1'b0);
    bus.addr_ready = 1'b1;
    bus.data_valid = 1'b0;
    @(negedge clk);
    check("bp_hs_addr_vld", bus.addr_valid, 1'b0);
    for (int j = 0; j < 3; j++) begin
      check("dw_data_rdy", bus.data_ready, 1'b1);
      check("dw_iv", inst_valid, 1'b0);
      @(negedge clk);
    end
    check("dw_iv_before", inst_valid, 1'b0);
    bus.data_valid = 1'b1;
    bus.data       = 32'h0000_0013;
    @(negedge clk);
    bus.data_valid = 1'b0;
    check("dw_iv", inst_valid, 1'b1);
    check("dw_inst", inst, 32'h0000_0013);
    check("dw_busy", busy, 1'b0);
    @(negedge clk);
    check("dw_iv_once", inst_valid, 1'b0);
    check("dw_inst_hold", inst, 32'h0000_0013);

    // Pending fetches: 0x24 is overwritten by 0x28 before the 0x20 read completes.
    bus.addr_ready = 1'b1;
    bus.data_valid = 1'b0;
    @(negedge clk);
    inst_fetch = 1'b1;
    pc         = 32'h0000_0020;
    @(negedge clk);
    inst_fetch = 1'b0;
    @(negedge clk);
    check("pd_data_rdy", bus.data_ready, 1'b1);
    inst_fetch = 1'b1;
    pc         = 32'h0000_0024;
    @(negedge clk);
    check("pd_busy1", busy, 1'b1);
    pc = 32'h0000_0028;
    @(negedge clk);
    inst_fetch     = 1'b0;
    check("pd_busy2", busy, 1'b1);
    check("pd_iv_wait", inst_valid, 1'b0);
    bus.data_valid = 1'b1;
    bus.data       = 32'hAAAA_0020;
    @(negedge clk);
    check("pd_iv1", inst_valid, 1'b1);
    check("pd_inst1", inst, 32'hAAAA_0020);
    check("pd_reissue_vld", bus.addr_valid, 1'b1);
    check("pd_reissue_addr", bus.addr, 32'h28);
    check("pd_busy3", busy, 1'b1);
    bus.data = 32'hBBBB_0028;
    @(negedge clk);
    check("pd_iv_gap", inst_valid, 1'b0);
    check("pd_busy4", busy, 1'b1);
    check("pd_data_rdy2", bus.data_ready, 1'b1);
    @(negedge clk);
    check("pd_iv2", inst_valid, 1'b1);
    check("pd_inst2", inst, 32'hBBBB_0028);
    check("pd_busy_off", busy, 1'b0);
    @(negedge clk);
    check("pd_no_0x24", bus.addr_valid, 1'b0);
    check("pd_iv_end", inst_valid, 1'b0);

    // Asynchronous reset while waiting in the address phase.
    bus.addr_ready = 1'b0;
    bus.data_valid = 1'b0;
    @(negedge clk);
    inst_fetch = 1'b1;
    pc         = 32'h0000_0030;
    @(negedge clk);
    inst_fetch = 1'b0;
    check("mr_in_addr", bus.addr_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mr_inst", inst, 0);
    check("mr_iv", inst_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_addr_vld", bus.addr_valid, 0);
    check("mr_addr", bus.addr, 0);
    check("mr_data_rdy", bus.data_ready, 0);
    @(negedge clk);
    rst            = 1'b0;
    bus.addr_ready = 1'b1;
    bus.data_valid = 1'b1;
    bus.data       = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      check("mr_late_iv", inst_valid, 1'b0);
      check("mr_late_busy", busy, 1'b0);
    end
    basic_fetch("after_rst");

    // Randomized traffic against a transaction-level model.
    bus.addr_ready = 1'b0;
    bus.data_valid = 1'b0;
    m_inflight = 1'b0;
    m_pend     = 1'b0;
    m_pend_pc  = '0;
    m_busy     = 1'b0;
    exp_iv     = 1'b0;
    exp_word   = '0;
    cur_word   = '0;
    prev_stall = 1'b0;
    prev_addr  = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      drain = (cyc >= 2950);
      check("r_busy", busy, m_busy);
      check("r_iv", inst_valid, exp_iv);
      if (exp_iv) check("r_inst", inst, exp_word);
      if (prev_stall) begin
        check("r_hold_vld", bus.addr_valid, 1'b1);
        check("r_hold_addr", bus.addr, prev_addr);
      end

      inst_fetch     = !drain && ($urandom_range(0, 3) == 0);
      pc             = $urandom;
      bus.addr_ready = drain || ($urandom_range(0, 1) == 1);
      bus.data_valid = drain || ($urandom_range(0, 1) == 1);
      bus.data       = bus.data_ready ? cur_word : $urandom;

      if (inst_fetch) begin
        if (m_inflight) begin
          m_pend    = 1'b1;
          m_pend_pc = pc;
        end else begin
          m_inflight = 1'b1;
          iq.push_back(pc);
        end
      end
      if (bus.addr_valid && bus.addr_ready) begin
        if (iq.size() == 0) begin
          check("r_spurious_issue", bus.addr_valid, 1'b0);
        end else begin
          a = iq.pop_front();
          check("r_issue_addr", bus.addr, a);
          cur_word = word_of(a);
        end
      end
      done_now = bus.data_ready && bus.data_valid;
      if (done_now) begin
        exp_word = cur_word;
        if (m_pend) begin
          iq.push_back(m_pend_pc);
          m_pend = 1'b0;
        end else begin
          m_inflight = 1'b0;
        end
      end
      exp_iv     = done_now;
      m_busy     = m_inflight || m_pend;
      prev_stall = bus.addr_valid && !bus.addr_ready;
      prev_addr  = bus.addr;
    end
    @(negedge clk);
    check("r_drain_queue", iq.size(), 0);
    check("r_drain_busy", busy, 1'b0);
    check("r_drain_addr_vld", bus.addr_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
